// File: rtl/addsub_xor_pipe_pkg.sv
// Shared opcodes and flag-vector layout for the add/sub/xor pipeline.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;

    localparam int FLG_C = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;
    localparam int FLG_W = 4;

    typedef logic [1:0]       op_t;
    typedef logic [FLG_W-1:0] flags_t;

endpackage

// File: rtl/addsub_xor_pipe_if.sv
// Request/result handshake bundle for addsub_xor_pipe.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs.
interface addsub_xor_pipe_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_c;
    logic             out_v;
    logic             out_z;
    logic             out_n;

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_res, out_c, out_v, out_z, out_n
    );

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_res, out_c, out_v, out_z, out_n
    );

endinterface

// File: rtl/addsub_xor_pipe_xor_vec_cond.sv
// Broadcast XOR: inverts every bit of a when b is set.
// Latency: combinational.
// Backpressure: none.
module xor_vec_cond #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic             b,
    output logic [WIDTH-1:0] out
);

    assign out = a ^ {WIDTH{b}};

endmodule

// File: rtl/addsub_xor_pipe.sv
// Two-stage ALU: stage 1 conditions operands, stage 2 adds and forms flags.
// Latency: 2 cycles, one request per cycle.
// Backpressure: stages hold on !out_ready; in_ready falls only with both stages full.
module addsub_xor_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    addsub_xor_pipe_if.slave   io
);

    logic             adv1;
    logic             adv2;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic             s1_cin;
    op_t              s1_op;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_res;
    flags_t           s2_flags;

    logic [WIDTH-1:0] b_cond;
    logic [WIDTH-1:0] a_cond;
    logic [WIDTH-1:0] x_nx;
    logic [WIDTH-1:0] y_nx;
    logic             cin_nx;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_nx;
    flags_t           flags_nx;

    // in_ready is the only combinational path (from out_ready).
    assign adv2        = !s2_valid || io.out_ready;
    assign adv1        = !s1_valid || adv2;
    assign io.in_ready = adv1;

    xor_vec_cond #(.WIDTH(WIDTH)) u_inv_b (
        .a   (io.in_b),
        .b   (io.in_op == OP_SUB),
        .out (b_cond)
    );

    xor_vec_cond #(.WIDTH(WIDTH)) u_inv_a (
        .a   (io.in_a),
        .b   (io.in_op == OP_INV),
        .out (a_cond)
    );

    always_comb begin
        x_nx   = io.in_a;
        y_nx   = io.in_b;
        cin_nx = 1'b0;
        case (io.in_op)
            OP_SUB: begin
                y_nx   = b_cond;
                cin_nx = 1'b1;
            end
            OP_XOR: begin
                x_nx = io.in_a ^ io.in_b;
                y_nx = '0;
            end
            OP_INV: begin
                x_nx = a_cond;
                y_nx = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_cin   <= 1'b0;
            s1_op    <= OP_ADD;
        end else if (adv1) begin
            s1_valid <= io.in_valid;
            if (io.in_valid) begin
                s1_x   <= x_nx;
                s1_y   <= y_nx;
                s1_cin <= cin_nx;
                s1_op  <= io.in_op;
            end
        end
    end

    assign sum = {1'b0, s1_x} + {1'b0, s1_y} + {{WIDTH{1'b0}}, s1_cin};

    always_comb begin
        res_nx   = s1_x;
        flags_nx = '0;
        if (s1_op == OP_ADD || s1_op == OP_SUB) begin
            res_nx          = sum[WIDTH-1:0];
            flags_nx[FLG_C] = sum[WIDTH];
            // Overflow uses the post-inversion y so SUB needs no special case.
            flags_nx[FLG_V] = (s1_x[WIDTH-1] == s1_y[WIDTH-1]) &&
                              (sum[WIDTH-1] != s1_x[WIDTH-1]);
        end
        flags_nx[FLG_Z] = (res_nx == '0);
        flags_nx[FLG_N] = res_nx[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_flags <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res   <= res_nx;
                s2_flags <= flags_nx;
            end
        end
    end

    assign io.out_valid = s2_valid;
    assign io.out_res   = s2_res;
    assign io.out_c     = s2_flags[FLG_C];
    assign io.out_v     = s2_flags[FLG_V];
    assign io.out_z     = s2_flags[FLG_Z];
    assign io.out_n     = s2_flags[FLG_N];

endmodule
